// File: rtl/bp_me_io_master_arbiter.sv
// bp_me_io_master_arbiter
//
// Purpose: shares one host I/O link between num_req_p I/O masters, such as
// the nbf loader, the cce cfg loader and debug/host masters. Commands are
// arbitrated onto the link. The ID of the issuing master is kept in a FIFO
// for each outstanding request. Link responses come back in order, so the
// FIFO head names the master that gets each response.
//
// Parameters:
//   num_req_p          number of master ports (>= 2)
//   max_outstanding_p  depth of the in-flight master-ID FIFO (>= 1)
//   msg_width_p        width of one cce_mem message; set this to
//                      cce_mem_msg_width of the chosen BlackParrot config
//
// Ports:
//   clk_i           clock
//   reset_i         synchronous, active-high reset
//   cmd_i           per-master command, master m at [m*msg_width_p +: msg_width_p]
//   cmd_v_i         per-master command valid
//   cmd_yumi_o      per-master command consumed
//   resp_o          response, broadcast to all masters
//   resp_v_o        per-master response valid, one-hot or zero
//   resp_ready_i    per-master response ready
//   io_cmd_o        link command
//   io_cmd_v_o      link command valid (never depends on io_cmd_ready_i)
//   io_cmd_ready_i  link command ready
//   io_resp_i       link response
//   io_resp_v_i     link response valid
//   io_resp_yumi_o  link response consumed
//   error_o         sticky: a response arrived with nothing outstanding
//
// Build option:
//   BP_IO_ARB_FIXED_PRIORITY_EN  when defined, the lowest-index valid master
//                                wins. When undefined (default), arbitration
//                                is round-robin.
//
// Arbitration FSM:
//   state    | meaning
//   e_idle   | grant chosen fresh each cycle by the arbiter
//   e_locked | link stalled an offered command; grant held until handshake

module bp_me_io_master_arbiter #(
  parameter int num_req_p         = 2,
  parameter int max_outstanding_p = 4,
  parameter int msg_width_p       = 64
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p*msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]           cmd_v_i,
  output logic [num_req_p-1:0]           cmd_yumi_o,
  output logic [msg_width_p-1:0]         resp_o,
  output logic [num_req_p-1:0]           resp_v_o,
  input  logic [num_req_p-1:0]           resp_ready_i,
  output logic [msg_width_p-1:0]         io_cmd_o,
  output logic                           io_cmd_v_o,
  input  logic                           io_cmd_ready_i,
  input  logic [msg_width_p-1:0]         io_resp_i,
  input  logic                           io_resp_v_i,
  output logic                           io_resp_yumi_o,
  output logic                           error_o
);

  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

  typedef enum logic {e_idle, e_locked} state_e;

  state_e                  state_q, state_n;
  logic [id_width_lp-1:0]  grant_q, grant, arb_grant;
  logic                    found;
  logic                    cmd_hs, resp_hs, pop, full, empty;

  logic [id_width_lp-1:0]  id_mem_q [max_outstanding_p];
  logic [ptr_width_lp-1:0] wptr_q, rptr_q;
  logic [cnt_width_lp-1:0] count_q;
  logic [id_width_lp-1:0]  head;

`ifndef BP_IO_ARB_FIXED_PRIORITY_EN
  logic [id_width_lp-1:0]  rr_ptr_q;
  logic [id_width_lp-1:0]  idx;
`endif

  // Arbiter
  always_comb begin
    arb_grant = '0;
    found     = 1'b0;
`ifdef BP_IO_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && cmd_v_i[i]) begin
        arb_grant = id_width_lp'(i);
        found     = 1'b1;
      end
    end
`else
    idx = '0;
    // Scan starts at rr_ptr and wraps, so the first hit is the next master in rotation.
    for (int i = 0; i < num_req_p; i++) begin
      idx = id_width_lp'((int'(rr_ptr_q) + i) % num_req_p);
      if (!found && cmd_v_i[idx]) begin
        arb_grant = idx;
        found     = 1'b1;
      end
    end
`endif
  end

  assign grant = (state_q == e_locked) ? grant_q : arb_grant;

  assign full       = (count_q == cnt_width_lp'(max_outstanding_p));
  assign empty      = (count_q == '0);
  assign io_cmd_v_o = cmd_v_i[grant] & ~full;
  assign cmd_hs     = io_cmd_v_o & io_cmd_ready_i;

  always_comb begin
    io_cmd_o   = '0;
    cmd_yumi_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant == id_width_lp'(i)) begin
        io_cmd_o      = cmd_i[i*msg_width_p +: msg_width_p];
        cmd_yumi_o[i] = cmd_hs;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      e_idle:   if (io_cmd_v_o && !io_cmd_ready_i) state_n = e_locked;
      e_locked: if (cmd_hs)                       state_n = e_idle;
      default:                                    state_n = e_idle;
    endcase
  end

  // Response routing. With nothing outstanding, the response is dropped.
  assign head           = id_mem_q[rptr_q];
  assign resp_o         = io_resp_i;
  assign io_resp_yumi_o = io_resp_v_i & (empty | resp_ready_i[head]);
  assign resp_hs        = io_resp_yumi_o;
  assign pop            = resp_hs & ~empty;

  always_comb begin
    resp_v_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      resp_v_o[i] = io_resp_v_i & ~empty & (head == id_width_lp'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      grant_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      error_o  <= 1'b0;
`ifndef BP_IO_ARB_FIXED_PRIORITY_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q <= state_n;
      grant_q <= grant;
      if (cmd_hs) begin
        id_mem_q[wptr_q] <= grant;
        wptr_q <= (wptr_q == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : wptr_q + 1'b1;
`ifndef BP_IO_ARB_FIXED_PRIORITY_EN
        rr_ptr_q <= id_width_lp'((int'(grant) + 1) % num_req_p);
`endif
      end
      if (pop) begin
        rptr_q <= (rptr_q == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : rptr_q + 1'b1;
      end
      if (cmd_hs && !pop)      count_q <= count_q + 1'b1;
      else if (!cmd_hs && pop) count_q <= count_q - 1'b1;
      if (resp_hs && empty)    error_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_me_io_master_arbiter.sv
module tb_bp_me_io_master_arbiter;

  localparam int W = 64;
  localparam int N = 2;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] cmd_i;
  logic [N-1:0]   cmd_v_i, cmd_yumi_o, resp_v_o, resp_ready_i;
  logic [W-1:0]   resp_o, io_cmd_o, io_resp_i;
  logic           io_cmd_v_o, io_cmd_ready_i, io_resp_v_i, io_resp_yumi_o, error_o;

  always #5 clk = ~clk;

  bp_me_io_master_arbiter #(.num_req_p(N), .max_outstanding_p(D), .msg_width_p(W)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_yumi_o(cmd_yumi_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .error_o(error_o)
  );

  typedef struct packed { logic [N-1:0] oh; logic [W-1:0] data; } exp_t;

  exp_t exp_cmd_q[$];
  exp_t exp_resp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int m);
    logic [N-1:0] one;
    one = 1;
    return one << m;
  endfunction

  function automatic int exp_grant(input int c);
`ifdef BP_IO_ARB_FIXED_PRIORITY_EN
    return 0;
`else
    return c % N;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int m, input logic [W-1:0] d);
    cmd_i[m*W +: W] = d;
  endtask

  task automatic push_cmd(input int m, input logic [W-1:0] d);
    exp_cmd_q.push_back({oh(m), d});
  endtask

  task automatic push_resp(input logic [N-1:0] o, input logic [W-1:0] d);
    exp_resp_q.push_back({o, d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_i = '0; cmd_v_i = '0; resp_ready_i = '0;
    io_cmd_ready_i = 1'b0; io_resp_v_i = 1'b0; io_resp_i = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: compares at the negedge, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (io_cmd_v_o && io_cmd_ready_i) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected: got %0h expected none", io_cmd_o);
        end else begin
          e = exp_cmd_q.pop_front();
          check("io_cmd_o", io_cmd_o, e.data);
          check("cmd_yumi_o", W'(cmd_yumi_o), W'(e.oh));
        end
      end
      if (io_resp_yumi_o) begin
        if (exp_resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got %0h expected none", resp_o);
        end else begin
          e = exp_resp_q.pop_front();
          check("resp_v_o", W'(resp_v_o), W'(e.oh));
          check("resp_o", resp_o, e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int grants[8];

  initial begin
    // Reset values
    reset = 1'b1;
    cmd_i = '0; cmd_v_i = '0; resp_ready_i = '0;
    io_cmd_ready_i = 1'b0; io_resp_v_i = 1'b0; io_resp_i = '0;
    cyc();
    @(negedge clk);
    check("rst_cmd_yumi", W'(cmd_yumi_o), 0);
    check("rst_resp_v", W'(resp_v_o), 0);
    check("rst_io_cmd_v", W'(io_cmd_v_o), 0);
    check("rst_io_resp_yumi", W'(io_resp_yumi_o), 0);
    check("rst_error", W'(error_o), 0);

    // Single master, three commands, in-order responses
    do_reset();
    io_cmd_ready_i = 1'b1;
    cmd_v_i = 2'b01;
    for (int n = 0; n < 3; n++) begin
      set_cmd(0, W'(64'hA000 + n));
      push_cmd(0, W'(64'hA000 + n));
      cyc();
    end
    cmd_v_i = '0;
    resp_ready_i = 2'b01;
    for (int n = 0; n < 3; n++) begin
      io_resp_v_i = 1'b1;
      io_resp_i = W'(64'hB000 + n);
      push_resp(2'b01, W'(64'hB000 + n));
      cyc();
    end
    io_resp_v_i = 1'b0;
    @(negedge clk);
    check("t1_no_error", W'(error_o), 0);

    // Both masters valid every cycle, responses returned each cycle
    do_reset();
    io_cmd_ready_i = 1'b1;
    resp_ready_i = 2'b11;
    for (int c = 0; c < 8; c++) begin
      cmd_v_i = 2'b11;
      set_cmd(0, W'(64'hC000 + c));
      set_cmd(1, W'(64'hD000 + c));
      grants[c] = exp_grant(c);
      push_cmd(grants[c], (grants[c] == 1) ? W'(64'hD000 + c) : W'(64'hC000 + c));
      if (c >= 1) begin
        io_resp_v_i = 1'b1;
        io_resp_i = W'(64'hE000 + c);
        push_resp(oh(grants[c-1]), W'(64'hE000 + c));
      end else begin
        io_resp_v_i = 1'b0;
      end
      cyc();
    end
    cmd_v_i = '0;
    io_resp_v_i = 1'b1;
    io_resp_i = W'(64'hE008);
    push_resp(oh(grants[7]), W'(64'hE008));
    cyc();
    io_resp_v_i = 1'b0;

    // Lock: link stalls master 1 while master 0 joins
    do_reset();
    set_cmd(0, W'(64'h1110));
    set_cmd(1, W'(64'h2221));
    for (int k = 0; k < 5; k++) begin
      cmd_v_i = (k >= 2) ? 2'b11 : 2'b10;
      @(negedge clk);
      check("lock_cmd_v", W'(io_cmd_v_o), 1);
      check("lock_cmd_data", io_cmd_o, W'(64'h2221));
      check("lock_no_yumi", W'(cmd_yumi_o), 0);
      cyc();
    end
    io_cmd_ready_i = 1'b1;
    cmd_v_i = 2'b11;
    push_cmd(1, W'(64'h2221));
    cyc();
    cmd_v_i = 2'b01;
    push_cmd(0, W'(64'h1110));
    cyc();
    cmd_v_i = '0;
    resp_ready_i = 2'b11;
    io_resp_v_i = 1'b1;
    io_resp_i = W'(64'hF1);
    push_resp(2'b10, W'(64'hF1));
    cyc();
    io_resp_i = W'(64'hF0);
    push_resp(2'b01, W'(64'hF0));
    cyc();
    io_resp_v_i = 1'b0;

    // FIFO full blocks issue; one response frees a slot for the next cycle
    do_reset();
    io_cmd_ready_i = 1'b1;
    cmd_v_i = 2'b01;
    for (int n = 0; n < 4; n++) begin
      set_cmd(0, W'(64'h4000 + n));
      push_cmd(0, W'(64'h4000 + n));
      cyc();
    end
    set_cmd(0, W'(64'h4004));
    @(negedge clk);
    check("full_blocks", W'(io_cmd_v_o), 0);
    cyc();
    io_resp_v_i = 1'b1;
    io_resp_i = W'(64'h5000);
    resp_ready_i = 2'b01;
    push_resp(2'b01, W'(64'h5000));
    @(negedge clk);
    check("full_no_bypass", W'(io_cmd_v_o), 0);
    cyc();
    io_resp_v_i = 1'b0;
    push_cmd(0, W'(64'h4004));
    @(negedge clk);
    check("full_resume", W'(io_cmd_v_o), 1);
    cyc();
    cmd_v_i = '0;
    for (int n = 0; n < 4; n++) begin
      io_resp_v_i = 1'b1;
      io_resp_i = W'(64'h5001 + n);
      push_resp(2'b01, W'(64'h5001 + n));
      cyc();
    end
    io_resp_v_i = 1'b0;

    // Response with nothing outstanding
    do_reset();
    io_resp_v_i = 1'b1;
    io_resp_i = W'(64'h6000);
    push_resp(2'b00, W'(64'h6000));
    @(negedge clk);
    check("orphan_yumi", W'(io_resp_yumi_o), 1);
    cyc();
    io_resp_v_i = 1'b0;
    @(negedge clk);
    check("error_set", W'(error_o), 1);
    repeat (3) cyc();
    @(negedge clk);
    check("error_sticky", W'(error_o), 1);
    reset = 1'b1;
    cyc();
    @(negedge clk);
    check("error_cleared", W'(error_o), 0);
    reset = 1'b0;
    cyc();

    check("cmd_q_drained", W'(exp_cmd_q.size()), 0);
    check("resp_q_drained", W'(exp_resp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
